// File: rtl/ysyx_25040111_pcctl.sv
// ysyx_25040111_pcctl -- program-counter / fetch sequencing controller.
//
// Runs one instruction at a time through REQ -> WAIT -> DEC -> EXEC and
// back to REQ. It handles sequential advance, jal/jalr/branch redirects
// and the instruction-address-misaligned trap via TRAP.
//
// Ports
//   clock, rst_n          : clock, synchronous active-low reset
//   ifu_req_valid/_ready  : fetch request handshake, address on ifu_req_pc
//   ifu_rsp_valid/_inst   : fetched instruction (taken only while waiting)
//   idu_valid/_ready      : decode handshake, idu_inst / idu_pc
//   exu_done/_jump/_target: execution result and redirect
//   trap_vec              : trap handler address
//   exc_valid/_ack        : misaligned-target trap handshake, exc_pc/exc_tval
//   instret               : 64-bit retired-instruction counter
module ysyx_25040111_pcctl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_pc,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic        idu_valid,
  input  logic        idu_ready,
  output logic [31:0] idu_inst,
  output logic [31:0] idu_pc,
  input  logic        exu_done,
  input  logic        exu_jump,
  input  logic [31:0] exu_target,
  input  logic [31:0] trap_vec,
  output logic        exc_valid,
  input  logic        exc_ack,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_tval,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DEC, S_EXEC, S_TRAP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic [31:0] exc_tval_q, exc_tval_d;
  logic [63:0] instret_q, instret_d;

  // jalr semantics: bit0 of the target is always discarded.
  logic [31:0] jump_tgt;
  // Trap vectors are word aligned; the low two bits are dropped.
  logic [31:0] trap_tgt;

  assign jump_tgt = exu_target & 32'hFFFF_FFFE;
  assign trap_tgt = trap_vec   & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    exc_pc_d   = exc_pc_q;
    exc_tval_d = exc_tval_q;
    instret_d  = instret_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (ifu_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ifu_rsp_valid) begin
          ir_d    = ifu_rsp_inst;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        if (idu_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exu_done) begin
          if (!exu_jump) begin
            pc_d      = pc_q + 32'd4;
            instret_d = instret_q + 64'd1;
            state_d   = S_REQ;
          end else if (!jump_tgt[1]) begin
            pc_d      = jump_tgt;
            instret_d = instret_q + 64'd1;
            state_d   = S_REQ;
          end else begin
            // Misaligned target: the jump does not retire and pc stays put
            // until the trap is accepted.
            exc_pc_d   = pc_q;
            exc_tval_d = jump_tgt;
            state_d    = S_TRAP;
          end
        end
      end
      S_TRAP: begin
        if (exc_ack) begin
          pc_d    = trap_tgt;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      exc_pc_q   <= 32'd0;
      exc_tval_q <= 32'd0;
      instret_q  <= 64'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      exc_pc_q   <= exc_pc_d;
      exc_tval_q <= exc_tval_d;
      instret_q  <= instret_d;
    end
  end

  // Handshake valids are pure state decodes so they can never glitch on inputs.
  assign ifu_req_valid = (state_q == S_REQ);
  assign idu_valid     = (state_q == S_DEC);
  assign exc_valid     = (state_q == S_TRAP);

  assign ifu_req_pc = pc_q;
  assign idu_pc     = pc_q;
  assign idu_inst   = ir_q;
  assign exc_pc     = exc_pc_q;
  assign exc_tval   = exc_tval_q;
  assign instret    = instret_q;

endmodule
